// File: rtl/lvt_bram_dump_reader.sv
// Read-side sequencer for the 2W1R LVT BRAM: walks rd0 over a contiguous
// address range and streams every word out on a valid/ready interface.
//
// Handshake: a word moves from this block to the consumer on a rising edge
// where out_valid && out_ready. While out_valid is high and out_ready is low,
// out_data/out_addr/out_last hold their values, and out_valid stays high until
// the word is taken. The only exceptions are abort and rst, which withdraw the
// word.
//
// Data path: reads are credit-limited so that (buffered words + in-flight read)
// never exceeds 2. A returning read either goes straight out, when the buffer
// is empty and the consumer is ready, or it is pushed into a 2-entry buffer.
// This keeps a 1 word/cycle stream without ever dropping a returning word.
module lvt_bram_dump_reader #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [CNT_W-1:0]  count,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              rd0_en,
    output logic [ADDR_W-1:0] rd0_addr,
    input  logic [DATA_W-1:0] rd0_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  issued_q;

    logic              inflight_q;
    logic [ADDR_W-1:0] inflight_addr_q;
    logic              inflight_last_q;

    logic [DATA_W-1:0] e0_data, e1_data;
    logic [ADDR_W-1:0] e0_addr, e1_addr;
    logic              e0_last, e1_last;
    logic [1:0]        occ_q;

    logic accept_start, issue, last_issue, bypass, xfer, push, pop;

    // Issue/credit and output-buffer control decoded from current state.
    always_comb begin
        accept_start = (state == IDLE) && start && !abort;
        issue        = (state == RUN) && !abort && ((occ_q + {1'b0, inflight_q}) < 2'd2);
        last_issue   = issue && (issued_q == (cnt_q - CNT_W'(1)));
        bypass       = (occ_q == 2'd0) && inflight_q;
        out_valid    = (occ_q != 2'd0) || inflight_q;
        out_data     = bypass ? rd0_data        : e0_data;
        out_addr     = bypass ? inflight_addr_q : e0_addr;
        out_last     = bypass ? inflight_last_q : e0_last;
        xfer         = out_valid && out_ready;
        pop          = xfer && (occ_q != 2'd0);
        push         = inflight_q && !(bypass && out_ready);
        rd0_en       = issue;
        rd0_addr     = addr_q;
        busy         = (state != IDLE);
        done         = (state == FIN);
        dbg_state    = state;
    end

    // Next-state logic; abort overrides everything and returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_start) state_nxt = (count == '0) ? FIN : RUN;
            RUN:     if (last_issue) state_nxt = DRAIN;
            DRAIN:   if (xfer && out_last) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Burst address and issued-read counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            cnt_q    <= '0;
            issued_q <= '0;
        end else if (accept_start) begin
            addr_q   <= start_addr;
            cnt_q    <= count;
            issued_q <= '0;
        end else if (issue) begin
            addr_q   <= addr_q + ADDR_W'(1);
            issued_q <= issued_q + CNT_W'(1);
        end
    end

    // Tracks the read whose data returns on the next cycle.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_addr_q <= addr_q;
                inflight_last_q <= last_issue;
            end
        end
    end

    // Two-entry output buffer; entry 0 is always the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q   <= 2'd0;
            e0_data <= '0;
            e0_addr <= '0;
            e0_last <= 1'b0;
            e1_data <= '0;
            e1_addr <= '0;
            e1_last <= 1'b0;
        end else if (abort) begin
            occ_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        e0_data <= rd0_data;
                        e0_addr <= inflight_addr_q;
                        e0_last <= inflight_last_q;
                    end else begin
                        e1_data <= rd0_data;
                        e1_addr <= inflight_addr_q;
                        e1_last <= inflight_last_q;
                    end
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    e0_data <= e1_data;
                    e0_addr <= e1_addr;
                    e0_last <= e1_last;
                    occ_q   <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        e0_data <= rd0_data;
                        e0_addr <= inflight_addr_q;
                        e0_last <= inflight_last_q;
                    end else begin
                        e0_data <= e1_data;
                        e0_addr <= e1_addr;
                        e0_last <= e1_last;
                        e1_data <= rd0_data;
                        e1_addr <= inflight_addr_q;
                        e1_last <= inflight_last_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
